abs_threshold_debounce: RTL and testbench

ABS_THRESHOLD_DEBOUNCE -- requirements
Module: abs_threshold_debounce

---
 rtl/abs_threshold_debounce_pkg.sv | 13 +
 rtl/abs_threshold_debounce_chan.sv | 108 ++++++++++
 rtl/abs_threshold_debounce.sv | 62 ++++++
 tb/tb_abs_threshold_debounce.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/abs_threshold_debounce_pkg.sv
// Shared types for the per-channel absolute-threshold debounce detector.
package abs_threshold_debounce_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_OFF    = 2'd0,
    ST_ARM    = 2'd1,
    ST_ON     = 2'd2,
    ST_DISARM = 2'd3
  } det_state_t;

endpackage

// File: rtl/abs_threshold_debounce_chan.sv
// One detector channel: magnitude register (stage 1) feeding a hysteresis/dwell FSM (stage 2).
module abs_threshold_debounce_chan
  import abs_threshold_debounce_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  sample,
  input  logic                 mag_valid,
  input  logic [IN_WIDTH-1:0]  thr_high,
  input  logic [IN_WIDTH-1:0]  thr_low,
  input  logic [CNT_WIDTH-1:0] dwell_on,
  input  logic [CNT_WIDTH-1:0] dwell_off,
  output det_state_t           state,
  output logic                 detect,
  output logic                 rise,
  output logic                 fall
);

  logic [IN_WIDTH-1:0]  mag;
  logic [IN_WIDTH-1:0]  mag_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 hit_high;
  logic                 below_low;

  // Two's-complement negate in IN_WIDTH bits: the most negative value maps to 2^(IN_WIDTH-1).
  assign mag_next  = sample[IN_WIDTH-1] ? (~sample + IN_WIDTH'(1)) : sample;
  assign hit_high  = (mag >= thr_high);
  assign below_low = (mag < thr_low);

  // Exit uses >= so a dwell lowered mid-count still exits instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag    <= '0;
      state  <= ST_OFF;
      cnt    <= '0;
      detect <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      if (in_valid) mag <= mag_next;
      rise <= 1'b0;
      fall <= 1'b0;
      if (mag_valid) begin
        unique case (state)
          ST_OFF: begin
            if (hit_high) begin
              if (dwell_on == '0) begin
                state  <= ST_ON;
                detect <= 1'b1;
                rise   <= 1'b1;
              end else begin
                state <= ST_ARM;
                cnt   <= CNT_WIDTH'(1);
              end
            end
          end
          ST_ARM: begin
            if (!hit_high) begin
              state <= ST_OFF;
              cnt   <= '0;
            end else if (cnt >= dwell_on) begin
              state  <= ST_ON;
              cnt    <= '0;
              detect <= 1'b1;
              rise   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          ST_ON: begin
            if (below_low) begin
              if (dwell_off == '0) begin
                state  <= ST_OFF;
                detect <= 1'b0;
                fall   <= 1'b1;
              end else begin
                state <= ST_DISARM;
                cnt   <= CNT_WIDTH'(1);
              end
            end
          end
          ST_DISARM: begin
            if (!below_low) begin
              state <= ST_ON;
              cnt   <= '0;
            end else if (cnt >= dwell_off) begin
              state  <= ST_OFF;
              cnt    <= '0;
              detect <= 1'b0;
              fall   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/abs_threshold_debounce.sv
// Multi-channel absolute-value threshold detector with hysteresis and dwell debounce, latency 2.
// Handshake: in_valid qualifies in_data for one cycle (no backpressure); out_valid is in_valid delayed 2.
module abs_threshold_debounce
  import abs_threshold_debounce_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  input  logic [IN_WIDTH-1:0]          thr_high,
  input  logic [IN_WIDTH-1:0]          thr_low,
  input  logic [CNT_WIDTH-1:0]         dwell_on,
  input  logic [CNT_WIDTH-1:0]         dwell_off,
  output logic                         out_valid,
  output logic [CHANNELS-1:0]          detect,
  output logic [CHANNELS-1:0]          rise,
  output logic [CHANNELS-1:0]          fall,
  output logic [CHANNELS*ST_W-1:0]     dbg_state
);

  logic s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    det_state_t st;

    abs_threshold_debounce_chan #(
      .IN_WIDTH (IN_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .sample   (in_data[k*IN_WIDTH +: IN_WIDTH]),
      .mag_valid(s1_valid),
      .thr_high (thr_high),
      .thr_low  (thr_low),
      .dwell_on (dwell_on),
      .dwell_off(dwell_off),
      .state    (st),
      .detect   (detect[k]),
      .rise     (rise[k]),
      .fall     (fall[k])
    );

    assign dbg_state[k*ST_W +: ST_W] = st;
  end

endmodule

// File: tb/tb_abs_threshold_debounce.sv
// Self-checking bench: directed scenarios plus randomized traffic against a run-length reference model.
module tb_abs_threshold_debounce;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int EW = 3 * CH;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [CH*W-1:0]   in_data;
  logic [W-1:0]      thr_high;
  logic [W-1:0]      thr_low;
  logic [CW-1:0]     dwell_on;
  logic [CW-1:0]     dwell_off;
  logic              out_valid;
  logic [CH-1:0]     detect;
  logic [CH-1:0]     rise;
  logic [CH-1:0]     fall;
  logic [CH*2-1:0]   dbg_state;

  abs_threshold_debounce #(.IN_WIDTH(W), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .thr_high(thr_high), .thr_low(thr_low), .dwell_on(dwell_on), .dwell_off(dwell_off),
    .out_valid(out_valid), .detect(detect), .rise(rise), .fall(fall), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // scoreboard: entries are {fall, rise, detect}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_ent;
  int            run[CH];
  bit            lvl[CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      lvl[c] = 1'b0;
    end
  endtask

  // Detect asserts once dwell_on+1 consecutive samples reach thr_high,
  // releases once dwell_off+1 consecutive samples fall below thr_low.
  task automatic model_step(input logic [CH*W-1:0] d);
    logic [CH-1:0] dv, rv, fv;
    logic signed [W-1:0] s;
    int mag;
    dv = '0; rv = '0; fv = '0;
    for (int c = 0; c < CH; c++) begin
      s = d[c*W +: W];
      mag = (int'(s) < 0) ? -int'(s) : int'(s);
      if (!lvl[c]) begin
        run[c] = (mag >= int'(thr_high)) ? run[c] + 1 : 0;
        if (run[c] > int'(dwell_on)) begin
          lvl[c] = 1'b1; rv[c] = 1'b1; run[c] = 0;
        end
      end else begin
        run[c] = (mag < int'(thr_low)) ? run[c] + 1 : 0;
        if (run[c] > int'(dwell_off)) begin
          lvl[c] = 1'b0; fv[c] = 1'b1; run[c] = 0;
        end
      end
      dv[c] = lvl[c];
    end
    m_ent = {fv, rv, dv};
    exp_q.push_back(m_ent);
  endtask

  // driver tasks
  task automatic send(input logic v, input logic [CH*W-1:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    if (v) model_step(d);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, '0);
  endtask

  function automatic logic [CH*W-1:0] one_ch(input int c, input int v);
    logic [CH*W-1:0] d;
    d = '0;
    d[c*W +: W] = W'(v);
    return d;
  endfunction

  task automatic set_ctrl(input int h, input int l, input int on, input int off);
    idle(2);
    thr_high  = W'(h);
    thr_low   = W'(l);
    dwell_on  = CW'(on);
    dwell_off = CW'(off);
  endtask

  task automatic do_reset();
    idle(3);
    @(posedge clk);
    #3;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_detect", detect, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_state", dbg_state, 0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  // compare process
  logic [1:0]    hist;
  logic [CH-1:0] hold_det;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!chk_en) begin
      hist     = 2'b00;
      hold_det = '0;
    end else begin
      chk("out_valid", out_valid, hist[1]);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: got out_valid with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("detect", detect, e[CH-1:0]);
          chk("rise", rise, e[2*CH-1:CH]);
          chk("fall", fall, e[3*CH-1:2*CH]);
          hold_det = e[CH-1:0];
        end
      end else begin
        chk("detect_hold", detect, hold_det);
        chk("rise_idle", rise, 0);
        chk("fall_idle", fall, 0);
      end
      hist = {hist[0], in_valid};
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    thr_high = 16'd256; thr_low = 16'd128; dwell_on = '0; dwell_off = '0;
    model_reset();
    do_reset();

    // basic hysteresis, dwell 0, ch0
    set_ctrl(256, 128, 0, 0);
    send(1'b1, one_ch(0, 0));    chk("s32_det1", m_ent[0], 0);
    send(1'b1, one_ch(0, 300));  chk("s32_det2", m_ent[0], 1); chk("s32_rise2", m_ent[CH], 1);
    send(1'b1, one_ch(0, 200));  chk("s32_det3", m_ent[0], 1); chk("s32_rise3", m_ent[CH], 0);
    send(1'b1, one_ch(0, 100));  chk("s32_det4", m_ent[0], 0); chk("s32_fall4", m_ent[2*CH], 1);

    // dwell_on=3 on ch1 with negative samples
    do_reset();
    set_ctrl(256, 128, 3, 0);
    repeat (3) send(1'b1, one_ch(1, -300));
    send(1'b1, one_ch(1, 0));    chk("s33_nodet", m_ent[1], 0);
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, one_ch(1, -300));
      chk($sformatf("s33_rise%0d", i), m_ent[CH+1], (i == 4));
    end

    // dwell_off=2 on ch2, re-arm to ON by a 200
    do_reset();
    set_ctrl(256, 128, 0, 2);
    send(1'b1, one_ch(2, 300));
    begin
      int seq[6] = '{50, 50, 200, 50, 50, 50};
      for (int i = 0; i < 6; i++) begin
        send(1'b1, one_ch(2, seq[i]));
        chk($sformatf("s34_fall%0d", i), m_ent[2*CH+2], (i == 5));
      end
    end

    // most negative sample against 2^(W-1)
    do_reset();
    set_ctrl(32768, 100, 0, 0);
    send(1'b1, one_ch(0, 32767));  chk("s35_pos", m_ent[0], 0);
    send(1'b1, one_ch(0, -32768)); chk("s35_neg", m_ent[0], 1);

    // valid gap inside ARM
    do_reset();
    set_ctrl(256, 128, 3, 0);
    send(1'b1, one_ch(0, 300));
    idle(1);
    send(1'b1, one_ch(0, 300));
    idle(2);
    send(1'b1, one_ch(0, 300));  chk("s36_pre", m_ent[0], 0);
    send(1'b1, one_ch(0, 300));  chk("s36_rise", m_ent[CH], 1);

    // reset during DISARM on ch3
    do_reset();
    set_ctrl(256, 128, 0, 2);
    send(1'b1, one_ch(3, 300));
    send(1'b1, one_ch(3, 50));
    idle(3);
    chk("s37_pre_det", detect[3], 1);
    chk("s37_pre_state", dbg_state[7:6], 3);
    do_reset();
    send(1'b1, one_ch(3, 50));   chk("s37_after", m_ent[3 + 2*CH], 0);
    send(1'b1, one_ch(3, 50));
    idle(3);

    // randomized traffic
    for (int seg = 0; seg < 8; seg++) begin
      set_ctrl($urandom_range(0, 600), $urandom_range(0, 600),
               $urandom_range(0, 3), $urandom_range(0, 3));
      for (int n = 0; n < 60; n++) begin
        logic [CH*W-1:0] d;
        d = '0;
        for (int c = 0; c < CH; c++) begin
          int v;
          case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 65535));
            1: v = int'(thr_high) + int'($urandom_range(0, 8)) - 4;
            2: v = int'(thr_low) + int'($urandom_range(0, 8)) - 4;
            default: v = int'($urandom_range(0, 20));
          endcase
          if ($urandom_range(0, 1) == 1) v = -v;
          d[c*W +: W] = W'(v);
        end
        send(($urandom_range(0, 9) < 7), d);
      end
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
